tlc5957_chain_tx: RTL
=====================

TLC5957_CHAIN_TX -- requirements
Module: tlc5957_chain_tx

Interface
REQ-001 SHALL have parameter NB_DRIVERS, default 1, number of TLC5957 devices daisy-chained on SIN/SOUT.
REQ-002 SHALL have parameter GS_BITS, default 9, grayscale bits sent per channel (legal 1..16), poker transfer mode.
REQ-003 SHALL have port clk, input, 1: system clock, single clock domain.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1: one-clk request to send a frame.
REQ-006 SHALL have port cmd, input, 1: 0 = grayscale frame, 1 = function-control (FC) write; sampled with start.
REQ-007 SHALL have port fc_data, input, 48: FC word, sampled with start, replicated to every driver.
REQ-008 SHALL have port busy, output, 1: high from clk after accepted start until done.
REQ-009 SHALL have port done, output, 1: one-clk pulse at frame end.
REQ-010 SHALL have port rd_en, output, 1: grayscale memory read strobe.
REQ-011 SHALL have port rd_addr, output, $clog2(48*NB_DRIVERS): read address = driver*48 + channel.
REQ-012 SHALL have port rd_data, input, GS_BITS: read data, valid exactly one clk after rd_en.
REQ-013 SHALL have ports SCLK, SIN, LAT, outputs, 1 each: serial interface to the chain.

Function
REQ-014 SHALL run states IDLE, LOAD, SHIFT, TAIL; IDLE->LOAD on start, LOAD->SHIFT after 1 clk, SHIFT->TAIL after last bit, TAIL->IDLE after 2 clk with done=1 on TAIL exit.
REQ-015 SHALL generate SCLK = clk/2 in SHIFT only; each bit is 2 clk: phase 0 SCLK=0 with SIN/LAT updated, phase 1 SCLK=1; SIN/LAT stable across the rising edge.
REQ-016 SHALL keep SCLK=0, LAT=0, SIN=0 outside SHIFT.
REQ-017 SHALL ignore start when busy=1; start sampled only in IDLE.
REQ-018 FC frame SHALL be 48*NB_DRIVERS bits, fc_data MSB first, repeated per driver.
REQ-019 FC frame SHALL drive LAT=1 for bits 1..15 (FCWRTEN) and for the last 5 bits (WRTFC), LAT=0 otherwise.
REQ-020 GS frame SHALL be GS_BITS words of 48*NB_DRIVERS bits; word order bit b = GS_BITS-1 down to 0; within word driver NB_DRIVERS-1 down to 0, channel 47 down to 0; SIN = rd_data[b].
REQ-021 GS frame SHALL drive LAT=1 on the last bit of each word for b>0 (WRTGS) and on the last 3 bits of the word for b=0 (LATGS).
REQ-022 SHALL issue exactly one rd_en per GS bit, in order of REQ-020, early enough that rd_data is registered before that bit's phase 0; first read issued in LOAD; no rd_en during FC frames.
REQ-023 SHALL shift exactly 48*NB_DRIVERS*GS_BITS (GS) or 48*NB_DRIVERS (FC) SCLK rising edges per frame, no extra edges.
REQ-024 Bit/word/driver counters SHALL wrap to zero at frame end; no state carries into next frame.

Reset
REQ-025 On rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, rd_en=0, rd_addr=0, SCLK=0, SIN=0, LAT=0, counters 0.
REQ-026 rst asserted mid-frame SHALL abort the frame; next start after release SHALL produce a complete frame from bit 0.

Verification
REQ-027 FC, NB_DRIVERS=1, fc_data=48'h5A5_A5A5_A5A5_A -> 48 SCLK rises, SIN equals fc_data MSB first, LAT high on rises 1-15 and 44-48, one done pulse, busy low after.
REQ-028 GS, NB_DRIVERS=1, GS_BITS=9, memory[ch]=ch+9'h100 -> 432 rises; first bit = memory[47][8]; LAT high only on rises 48,96,...,384 and 430-432.
REQ-029 GS, NB_DRIVERS=2 -> 96-bit words; first read addr 95, last read addr 0; rd_en count = 96*GS_BITS; LAT per REQ-021 at word ends only.
REQ-030 start pulsed 10 clk after accepted start and again during TAIL -> ignored, single frame/done; start in the clk after done -> accepted.
REQ-031 rst asserted at rise 200 of a GS frame -> SCLK, SIN, LAT, busy, rd_en 0 without a clk edge; subsequent FC start -> clean 48-bit FC frame per REQ-027.

Source files
------------

// File: rtl/tlc5957_chain_tx_if.sv
// Host/memory-side bundle of the TLC5957 chain transmitter.
// master: the transmitter itself; slave: frame requester plus grayscale memory.
interface tlc5957_chain_tx_if #(
   parameter int unsigned NB_DRIVERS = 1,
   parameter int unsigned GS_BITS    = 9
);
   localparam int unsigned AddrW = $clog2(48 * NB_DRIVERS);

   logic               start;
   logic               cmd;
   logic [47:0]        fc_data;
   logic               busy;
   logic               done;
   logic               rd_en;
   logic [AddrW-1:0]   rd_addr;
   logic [GS_BITS-1:0] rd_data;
   logic               SCLK;
   logic               SIN;
   logic               LAT;

   modport master (
      input  start, cmd, fc_data, rd_data,
      output busy, done, rd_en, rd_addr, SCLK, SIN, LAT
   );

   modport slave (
      output start, cmd, fc_data, rd_data,
      input  busy, done, rd_en, rd_addr, SCLK, SIN, LAT
   );
endinterface

// File: rtl/tlc5957_chain_tx.sv
// Serialises grayscale (poker mode, MSB plane first) or function-control frames onto a
// chain of TLC5957 drivers. Each bit takes two clocks: SCLK low with SIN/LAT updated,
// then SCLK high. SHIFT opens with one SCLK-low lead-in clock so the first read has landed.
module tlc5957_chain_tx #(
   parameter int unsigned NB_DRIVERS = 1,
   parameter int unsigned GS_BITS    = 9
) (
   input logic                clk,
   input logic                rst,
   tlc5957_chain_tx_if.master bus
);
   localparam int unsigned Width = 48 * NB_DRIVERS;
   localparam int unsigned AddrW = $clog2(Width);
   localparam int unsigned DrvW  = (NB_DRIVERS > 1) ? $clog2(NB_DRIVERS) : 1;
   localparam int unsigned WrdW  = (GS_BITS > 1) ? $clog2(GS_BITS) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StTail} state_e;

   state_e            state_q, state_d;
   logic              phase_q, phase_d;   // 0: SCLK-low half, 1: SCLK-high half or lead-in
   logic              last_q, last_d;     // final bit of the frame is on SIN
   logic              tail_q, tail_d;
   logic [5:0]        chan_q, chan_d;     // counters name the next bit to put on SIN
   logic [DrvW-1:0]   drv_q, drv_d;
   logic [WrdW-1:0]   wrd_q, wrd_d;
   logic              cmd_q, cmd_d;
   logic [47:0]       fc_q, fc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic [AddrW-1:0]  rd_addr_q, rd_addr_d;
   logic              sclk_q, sclk_d;
   logic              sin_q, sin_d;
   logic              lat_q, lat_d;

   logic              chan_end, drv_end, wrd_end, frame_end;
   logic [5:0]        chan_nx;
   logic [DrvW-1:0]   drv_nx;
   logic [WrdW-1:0]   wrd_nx;
   logic [WrdW-1:0]   bidx;
   logic              bit_val, bit_lat;

   // Channel 47 of the highest driver is stored at the top address and shifted first.
   function automatic logic [AddrW-1:0] addr_of(input logic [DrvW-1:0] drv,
                                                input logic [5:0] chan);
      int unsigned a;
      a = (NB_DRIVERS - 1 - 32'(drv)) * 48 + (47 - 32'(chan));
      return AddrW'(a);
   endfunction

   // Counter advance and the SIN/LAT value of the bit the counters point at.
   always_comb begin
      chan_end  = (chan_q == 6'd47);
      drv_end   = (drv_q == DrvW'(NB_DRIVERS - 1));
      wrd_end   = cmd_q || (wrd_q == WrdW'(GS_BITS - 1));
      frame_end = chan_end && drv_end && wrd_end;
      chan_nx   = chan_end ? 6'd0 : chan_q + 6'd1;
      drv_nx    = chan_end ? (drv_end ? '0 : drv_q + DrvW'(1)) : drv_q;
      wrd_nx    = (chan_end && drv_end) ? (wrd_end ? '0 : wrd_q + WrdW'(1)) : wrd_q;
      bidx      = WrdW'(GS_BITS - 1) - wrd_q;
      if (cmd_q) begin
         // FCWRTEN on the first 15 bits, WRTFC on the last 5.
         bit_val = fc_q[6'd47 - chan_q];
         bit_lat = ((drv_q == '0) && (chan_q < 6'd15)) || (drv_end && (chan_q >= 6'd43));
      end else begin
         // WRTGS on the last bit of each plane, LATGS on the last 3 bits of plane 0.
         bit_val = bus.rd_data[bidx];
         bit_lat = drv_end && ((bidx == '0) ? (chan_q >= 6'd45) : chan_end);
      end
   end

   // Frame sequencing and next values of every registered output.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      last_d    = last_q;
      tail_d    = tail_q;
      chan_d    = chan_q;
      drv_d     = drv_q;
      wrd_d     = wrd_q;
      cmd_d     = cmd_q;
      fc_d      = fc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      sclk_d    = 1'b0;
      sin_d     = 1'b0;
      lat_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StLoad;
               busy_d  = 1'b1;
               cmd_d   = bus.cmd;
               fc_d    = bus.fc_data;
               chan_d  = '0;
               drv_d   = '0;
               wrd_d   = '0;
               last_d  = 1'b0;
               phase_d = 1'b0;
               if (!bus.cmd) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = addr_of('0, '0);
               end
            end
         end
         StLoad: begin
            state_d = StShift;
            phase_d = 1'b1;
         end
         StShift: begin
            if (!phase_q) begin
               sclk_d  = 1'b1;
               sin_d   = sin_q;
               lat_d   = lat_q;
               phase_d = 1'b1;
            end else if (last_q) begin
               state_d = StTail;
               tail_d  = 1'b0;
               last_d  = 1'b0;
               phase_d = 1'b0;
            end else begin
               sin_d   = bit_val;
               lat_d   = bit_lat;
               phase_d = 1'b0;
               last_d  = frame_end;
               chan_d  = chan_nx;
               drv_d   = drv_nx;
               wrd_d   = wrd_nx;
               // Fetch the following bit now so it is on rd_data at the next bit boundary.
               if (!cmd_q && !frame_end) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = addr_of(drv_nx, chan_nx);
               end
            end
         end
         StTail: begin
            if (tail_q) begin
               state_d = StIdle;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               tail_d  = 1'b0;
            end else begin
               tail_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         phase_q   <= 1'b0;
         last_q    <= 1'b0;
         tail_q    <= 1'b0;
         chan_q    <= '0;
         drv_q     <= '0;
         wrd_q     <= '0;
         cmd_q     <= 1'b0;
         fc_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         sclk_q    <= 1'b0;
         sin_q     <= 1'b0;
         lat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         last_q    <= last_d;
         tail_q    <= tail_d;
         chan_q    <= chan_d;
         drv_q     <= drv_d;
         wrd_q     <= wrd_d;
         cmd_q     <= cmd_d;
         fc_q      <= fc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         sclk_q    <= sclk_d;
         sin_q     <= sin_d;
         lat_q     <= lat_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.SCLK    = sclk_q;
   assign bus.SIN     = sin_q;
   assign bus.LAT     = lat_q;
endmodule
